// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared size encodings, FSM state type and lane helpers for dmem_responder
package dmem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int WAIT_CYCLES_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_RSVD) ||
               ((size == SZ_HALF) && lo[0]) ||
               ((size == SZ_WORD) && (lo != 2'b00));
    endfunction

    // Natural alignment: drop the low address bits the access size cannot use.
    function automatic logic [1:0] aligned_lane(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return lo;
            SZ_HALF: return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_ext.sv
// rtl/dmem_lane_ext.sv - load lane select and sign/zero extension
module dmem_lane_ext
    import dmem_responder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_lane, 3'b000} +: 8];
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder for the memory stage
// Optional alignment fault reporting is enabled with DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam logic [3:0] LP_WAIT_LOAD =
        (WAIT_CYCLES > 0 && WAIT_CYCLES <= WAIT_CYCLES_MAX) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_uns;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_busy;

    logic [31:0] r_mem [0:(1 << ADDR_W) - 1];

    logic              w_in_idle;
    logic              w_acc_we;
    logic [31:0]       w_acc_addr;
    logic [31:0]       w_acc_wdata;
    logic [1:0]        w_acc_size;
    logic              w_acc_uns;
    logic              w_fault;
    logic              w_enter_resp;
    logic [1:0]        w_lane;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_ld_data;
    logic [31:0]       w_resp_data;
    logic [3:0]        w_be;
    logic [31:0]       w_wr_lanes;
    logic [31:0]       w_wr_word;
    logic              w_unused;

    // With no wait states the access happens on the accepting edge, so use the live request.
    assign w_in_idle   = (r_state == ST_IDLE);
    assign w_acc_we    = w_in_idle ? req_we       : r_we;
    assign w_acc_addr  = w_in_idle ? req_addr     : r_addr;
    assign w_acc_wdata = w_in_idle ? req_wdata    : r_wdata;
    assign w_acc_size  = w_in_idle ? req_size     : r_size;
    assign w_acc_uns   = w_in_idle ? req_unsigned : r_uns;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_fault = misaligned(w_acc_size, w_acc_addr[1:0]);
`else
    assign w_fault = 1'b0;
`endif

    assign w_enter_resp = (w_in_idle && req_valid && (WAIT_CYCLES == 0)) ||
                          ((r_state == ST_WAIT) && (r_cnt == 4'd0));

    assign w_lane    = aligned_lane(w_acc_size, w_acc_addr[1:0]);
    assign w_idx     = w_acc_addr[ADDR_W+1:2];
    assign w_rd_word = r_mem[w_idx];
    assign w_unused  = ^{req_addr[31:ADDR_W+2], r_addr[31:ADDR_W+2]};

    dmem_lane_ext u_lane_ext (
        .i_word     (w_rd_word),
        .i_lane     (w_lane),
        .i_size     (w_acc_size),
        .i_unsigned (w_acc_uns),
        .o_data     (w_ld_data)
    );

    assign w_resp_data = (w_acc_we || w_fault) ? 32'd0 : w_ld_data;

    always_comb begin
        w_be       = 4'b1111;
        w_wr_lanes = w_acc_wdata;
        case (w_acc_size)
            SZ_BYTE: begin
                w_be       = 4'b0001 << w_lane;
                w_wr_lanes = {4{w_acc_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be       = 4'b0011 << w_lane;
                w_wr_lanes = {2{w_acc_wdata[15:0]}};
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            w_wr_word[8*i +: 8] = w_be[i] ? w_wr_lanes[8*i +: 8] : w_rd_word[8*i +: 8];
        end
    end

    // Array is never reset; a store only commits if reset is not held at the commit edge.
    always_ff @(posedge clk) begin
        if (rst && w_enter_resp && w_acc_we && !w_fault) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_size       <= 2'b00;
            r_uns        <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_size      <= req_size;
                        r_uns       <= req_unsigned;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_resp_data;
                            r_resp_err   <= w_fault;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= LP_WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_resp_data;
                        r_resp_err   <= w_fault;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder with a behavioural memory model
module tb_dmem_responder;

    localparam int WAIT_CYCLES = 1;
    localparam int EXP_LAT     = WAIT_CYCLES + 1;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int n_checks;
    int n_errors;

    logic [31:0] mdl [0:1023];

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: little-endian memory of 1024 words, addresses wrap modulo 4 KiB.
    function automatic void model_access(input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [1:0] size,
                                         input logic uns, output logic [31:0] rdata,
                                         output logic err);
        int nb, off, idx;
        logic [63:0] m, v, wm;
        nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err   = 1'b0;
        rdata = 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
        if (size == 2'd3 || (addr % nb) != 0) err = 1'b1;
`endif
        off = int'(addr % 4) - (int'(addr % 4) % nb);
        idx = int'((addr / 4) % 1024);
        m   = (64'd1 << (8 * nb)) - 64'd1;
        if (err) return;
        if (we) begin
            wm       = m << (8 * off);
            v        = ({32'd0, mdl[idx]} & ~wm) | (({32'd0, wdata} & m) << (8 * off));
            mdl[idx] = v[31:0];
        end else begin
            v = ({32'd0, mdl[idx]} >> (8 * off)) & m;
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~m;
            rdata = v[31:0];
        end
    endfunction

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [1:0] size, input logic uns,
                             output logic [31:0] rdata, output logic err,
                             output int lat, output bit tmo);
        int n;
        tmo = 1'b0;
        lat = 0;
        rdata = 32'd0;
        err = 1'b0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tmo = 1'b1;
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        if (!resp_valid) begin
            tmo = 1'b1;
            return;
        end
        rdata      = resp_rdata;
        err        = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_err, busy} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b rdata=%h err=%b busy=%b, want 1 0 00000000 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL after_reset_idle: got rdy=%b busy=%b, want 1 0", req_ready, busy);
        end
    endtask

    task automatic test_word_and_bytes;
        logic [31:0] rd, md;
        logic er, me;
        int lat;
        bit tmo;
        logic [31:0] exp_rd [6];
        logic        ops_we [7];
        logic [31:0] ops_a  [7];
        logic [31:0] ops_d  [7];
        logic [1:0]  ops_s  [7];
        logic        ops_u  [7];
        logic [31:0] ops_e  [7];
        ops_we = '{1, 0, 0, 1, 0, 0, 0};
        ops_a  = '{32'h10, 32'h10, 32'h13, 32'h11, 32'h11, 32'h11, 32'h10};
        ops_d  = '{32'h12345678, 0, 0, 32'h80, 0, 0, 0};
        ops_s  = '{2, 2, 0, 0, 0, 0, 2};
        ops_u  = '{0, 0, 0, 0, 0, 1, 0};
        ops_e  = '{0, 32'h12345678, 32'h00000012, 0, 32'hFFFFFF80, 32'h00000080, 32'h12348078};
        exp_rd[0] = 32'd0;
        for (int i = 0; i < 7; i++) begin
            do_access(ops_we[i], ops_a[i], ops_d[i], ops_s[i], ops_u[i], rd, er, lat, tmo);
            model_access(ops_we[i], ops_a[i], ops_d[i], ops_s[i], ops_u[i], md, me);
            n_checks++;
            if (tmo || rd !== ops_e[i] || er !== 1'b0 || lat != EXP_LAT) begin
                n_errors++;
                $display("FAIL directed_op%0d: got rdata=%h err=%b lat=%0d tmo=%0d, want rdata=%h err=0 lat=%0d",
                         i, rd, er, lat, tmo, ops_e[i], EXP_LAT);
            end
        end
    endtask

    task automatic test_halfwords;
        logic [31:0] rd, md;
        logic er, me;
        int lat;
        bit tmo;
        do_access(1, 32'h10, 32'hFFFE0001, 2, 0, rd, er, lat, tmo);
        model_access(1, 32'h10, 32'hFFFE0001, 2, 0, md, me);
        do_access(0, 32'h12, 0, 1, 0, rd, er, lat, tmo);
        n_checks++;
        if (tmo || rd !== 32'hFFFFFFFE) begin
            n_errors++;
            $display("FAIL lh_signed: got %h tmo=%0d, want FFFFFFFE", rd, tmo);
        end
        do_access(0, 32'h12, 0, 1, 1, rd, er, lat, tmo);
        n_checks++;
        if (tmo || rd !== 32'h0000FFFE) begin
            n_errors++;
            $display("FAIL lhu: got %h tmo=%0d, want 0000FFFE", rd, tmo);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] md;
        logic me;
        int n;
        model_access(0, 32'h10, 0, 2, 0, md, me);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 50);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== md || req_ready !== 1'b0 || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL backpressure_hold%0d: got vld=%b rdata=%h rdy=%b busy=%b, want 1 %h 0 1",
                         c, resp_valid, resp_rdata, req_ready, busy, md);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b busy=%b, want 0 1 0",
                     resp_valid, req_ready, busy);
        end
    endtask

    task automatic test_align;
        logic [31:0] rd, md;
        logic er, me, exp_err;
        int lat;
        bit tmo;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_access(1, 32'h12, 32'hCAFEBABE, 2, 0, rd, er, lat, tmo);
        model_access(1, 32'h12, 32'hCAFEBABE, 2, 0, md, me);
        n_checks++;
        if (tmo || er !== exp_err || rd !== 32'd0) begin
            n_errors++;
            $display("FAIL misaligned_sw: got err=%b rdata=%h tmo=%0d, want err=%b rdata=0", er, rd, tmo, exp_err);
        end
        do_access(0, 32'h10, 0, 2, 0, rd, er, lat, tmo);
        model_access(0, 32'h10, 0, 2, 0, md, me);
        n_checks++;
        if (tmo || rd !== md || er !== 1'b0) begin
            n_errors++;
            $display("FAIL after_misaligned_lw: got %h err=%b, want %h err=0", rd, er, md);
        end
    endtask

    task automatic test_reset_midtx;
        logic [31:0] rd, md;
        logic er, me;
        int lat;
        bit tmo;
        do_access(1, 32'h20, 32'h0BADF00D, 2, 0, rd, er, lat, tmo);
        model_access(1, 32'h20, 32'h0BADF00D, 2, 0, md, me);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
        req_size = 2'd2; req_unsigned = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_err, busy} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_midtx_outputs: got rdy=%b vld=%b rdata=%h err=%b busy=%b, want 1 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_access(0, 32'h20, 0, 2, 0, rd, er, lat, tmo);
        n_checks++;
        if (tmo || rd !== 32'h0BADF00D) begin
            n_errors++;
            $display("FAIL reset_drops_store: got %h tmo=%0d, want 0BADF00D", rd, tmo);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, md, a, d;
        logic er, me, we, u;
        logic [1:0] s;
        int lat;
        bit tmo;
        for (int w = 0; w < 16; w++) begin
            d = $urandom;
            do_access(1, 32'(w * 4), d, 2, 0, rd, er, lat, tmo);
            model_access(1, 32'(w * 4), d, 2, 0, md, me);
        end
        for (int i = 0; i < 300; i++) begin
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            d  = $urandom;
            we = 1'($urandom_range(0, 1));
            s  = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            do_access(we, a, d, s, u, rd, er, lat, tmo);
            model_access(we, a, d, s, u, md, me);
            n_checks++;
            if (tmo || rd !== md || er !== me || lat != EXP_LAT) begin
                n_errors++;
                $display("FAIL random%0d we=%b a=%h d=%h s=%0d u=%b: got rdata=%h err=%b lat=%0d tmo=%0d, want rdata=%h err=%b lat=%0d",
                         i, we, a, d, s, u, rd, er, lat, tmo, md, me, EXP_LAT);
            end
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        resp_ready   = 1'b0;
        test_reset();
        test_word_and_bytes();
        test_halfwords();
        test_backpressure();
        test_align();
        test_reset_midtx();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 10, number of word-address bits (array depth 2^ADDR_W words of 32 bits).
REQ-002 Parameter WAIT_CYCLES, default 1, extra wait states inserted before each response (range 0..15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  datapath memory-stage request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address (from aluoutM).
REQ-009 req_wdata  input  32  store data (from writedataM), right-aligned.
REQ-010 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-011 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  datapath accepts response.
REQ-014 resp_rdata  output  32  extended load data (readdataM); 0 for stores.
REQ-015 resp_err  output  1  access faulted (see Configuration).
REQ-016 busy  output  1  request in flight; drives hazard-unit memory stall.

Function
REQ-017 FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE; busy = 1 in WAIT and RESP.
REQ-018 IDLE: on req_valid, latch all req_* fields; go to WAIT if WAIT_CYCLES > 0, else RESP.
REQ-019 WAIT: a 4-bit counter loaded with WAIT_CYCLES-1 decrements each cycle; at 0, go to RESP.
REQ-020 Array access (read capture and write commit) occurs on the edge entering RESP; resp_valid rises WAIT_CYCLES+1 cycles after acceptance.
REQ-021 RESP: hold resp_valid, resp_rdata and resp_err stable until resp_valid && resp_ready; then go to IDLE; a new request cannot be accepted in that same cycle.
REQ-022 Word index = req_addr[ADDR_W+1:2]; higher address bits are ignored (wrap-around).
REQ-023 Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1]; stores write only the selected lanes; the other bytes are preserved.
REQ-024 Loads: selected byte/half is shifted to bit 0 and extended per req_unsigned; word loads ignore req_unsigned.
REQ-025 A store followed by a load to the same address returns the stored data (no stale read).
REQ-026 Faulted accesses return resp_rdata = 0 and perform no write.

Reset
REQ-027 While rst = 0: state IDLE, counter 0, latched fields 0, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0.
REQ-028 Reset mid-transaction aborts it; a pending store not yet committed is dropped.
REQ-029 Array contents are not reset.

Configuration
REQ-030 With DMEM_ALIGN_CHECK_EN defined: half access with addr[0] = 1, word access with addr[1:0] != 0, or req_size = 11 sets resp_err = 1 and follows REQ-026.
REQ-031 Without DMEM_ALIGN_CHECK_EN: resp_err is tied to 0; the offending low address bits are forced to 0 (natural alignment); size 11 is treated as word.

Structure
REQ-032 Shared package holds size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state type and the WAIT_CYCLES range limit.
REQ-033 One sub-module, dmem_lane_ext: combinational load lane select and extension; all other logic is inline.

Verification
REQ-034 WAIT_CYCLES=1: sw 0x12345678 @0x10, then lw @0x10 -> resp_valid 2 cycles after each acceptance, rdata 0x12345678.
REQ-035 Byte loads of 0x12345678 @0x10: lb @0x13 -> 0x00000012; sb 0x80 @0x11 then lb @0x11 -> 0xFFFFFF80, lbu -> 0x00000080, lw -> 0x12348078.
REQ-036 lh @0x12 after sw 0xFFFE0001 -> 0xFFFFFFFE; lhu -> 0x0000FFFE.
REQ-037 Backpressure: hold resp_ready = 0 for 5 cycles -> resp_valid/rdata stable and req_ready = 0 throughout; handshake -> IDLE on the next cycle.
REQ-038 With DMEM_ALIGN_CHECK_EN: sw @0x12 -> resp_err = 1, later lw @0x10 unchanged; without it, same sw writes @0x10 and resp_err = 0.
REQ-039 Assert rst = 0 during WAIT of sw 0xAAAA5555 @0x20 -> outputs return to reset values immediately; later lw @0x20 returns the previous contents.
